// File: rtl/decoder_pkg.sv
// Shared defaults and helpers for the multi-port write enable decoder.
package decoder_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 5;
  localparam int unsigned DEFAULT_NUM_PORTS  = 2;
  localparam int unsigned DEFAULT_CNT_WIDTH  = 16;

  // Width of the rotating priority pointer: clog2 of the port count, never below 1.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational N-to-2**N one-hot decoder with enable.
module onehot_decoder #(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                     enable,
  input  logic [ADDR_WIDTH-1:0]    address,
  output logic [(2**ADDR_WIDTH)-1:0] out
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  // Single set bit at the requested address, or nothing when disabled.
  always_comb begin
    out = '0;
    if (enable) out = DEPTH'(1) << address;
  end

endmodule

// File: rtl/write_port_decoder.sv
// Registered multi-port write enable decoder with rotating-priority collision resolution.
// Optional: WRITE_PORT_DECODER_ZERO_MASK_EN treats address 0 as a hardwired zero register.
module write_port_decoder
  import decoder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned NUM_PORTS  = DEFAULT_NUM_PORTS,
  parameter int unsigned CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_PORTS-1:0]                 req_valid,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]      req_addr,
  output logic [NUM_PORTS-1:0]                 req_ready,
  output logic [NUM_PORTS*(2**ADDR_WIDTH)-1:0] enable_port,
  output logic [(2**ADDR_WIDTH)-1:0]           enable_out,
  output logic [CNT_WIDTH-1:0]                 collision_cnt
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;
  localparam int unsigned PTR_W = ptr_width(NUM_PORTS);

  logic [PTR_W-1:0]           r_prio_ptr;
  logic [NUM_PORTS*DEPTH-1:0] r_enable_port;
  logic [DEPTH-1:0]           r_enable_out;
  logic [CNT_WIDTH-1:0]       r_collision_cnt;

  logic [NUM_PORTS-1:0]       w_ready;
  logic [NUM_PORTS-1:0]       w_zero;
  logic [NUM_PORTS-1:0]       w_dec_en;
  logic [NUM_PORTS*DEPTH-1:0] w_dec;
  logic [DEPTH-1:0]           w_dec_or;
  logic                       w_collision;

  // Accept each valid port unless a higher-ranked valid port targets the same address.
  always_comb begin
    int unsigned rank_p;
    int unsigned rank_q;
    w_ready     = '0;
    w_zero      = '0;
    w_dec_en    = '0;
    w_collision = 1'b0;
    rank_p      = 0;
    rank_q      = 0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
`ifdef WRITE_PORT_DECODER_ZERO_MASK_EN
      w_zero[p] = (req_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == '0);
`endif
      if (req_valid[p] && !reset) begin
        w_ready[p] = 1'b1;
        rank_p = (p + NUM_PORTS - 32'(r_prio_ptr)) % NUM_PORTS;
        if (!w_zero[p]) begin
          for (int unsigned q = 0; q < NUM_PORTS; q++) begin
            rank_q = (q + NUM_PORTS - 32'(r_prio_ptr)) % NUM_PORTS;
            if ((q != p) && req_valid[q] && (rank_q < rank_p) &&
                (req_addr[q*ADDR_WIDTH +: ADDR_WIDTH] == req_addr[p*ADDR_WIDTH +: ADDR_WIDTH]))
              w_ready[p] = 1'b0;
          end
        end
      end
    end
    w_dec_en    = w_ready & ~w_zero;
    w_collision = !reset && ((req_valid & ~w_ready) != '0);
  end

  assign req_ready = w_ready;

  // One decoder per port, enabled only for accepted, non-masked requests.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_dec
    onehot_decoder #(.ADDR_WIDTH(ADDR_WIDTH)) u_dec (
      .enable  (w_dec_en[g]),
      .address (req_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .out     (w_dec[g*DEPTH +: DEPTH])
    );
  end

  // Merge per-port slices; arbitration guarantees they are disjoint.
  always_comb begin
    w_dec_or = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++)
      w_dec_or = w_dec_or | w_dec[p*DEPTH +: DEPTH];
  end

  // Output register stage, priority rotation and saturating collision counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_enable_port   <= '0;
      r_enable_out    <= '0;
      r_collision_cnt <= '0;
      r_prio_ptr      <= '0;
    end else begin
      r_enable_port <= w_dec;
      r_enable_out  <= w_dec_or;
      if (w_collision) begin
        if (r_prio_ptr == PTR_W'(NUM_PORTS - 1)) r_prio_ptr <= '0;
        else                                     r_prio_ptr <= r_prio_ptr + PTR_W'(1);
        if (r_collision_cnt != '1) r_collision_cnt <= r_collision_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign enable_port   = r_enable_port;
  assign enable_out    = r_enable_out;
  assign collision_cnt = r_collision_cnt;

endmodule

// File: tb/tb_write_port_decoder.sv
// Self-checking bench for write_port_decoder (ADDR_WIDTH=5, NUM_PORTS=2).
module tb_write_port_decoder;

  localparam int AW = 5;
  localparam int NP = 2;
  localparam int DP = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [NP-1:0]   req_valid;
  logic [NP*AW-1:0] req_addr;
  logic [NP-1:0]   req_ready, req_ready_s;
  logic [NP*DP-1:0] enable_port, enable_port_s;
  logic [DP-1:0]   enable_out, enable_out_s;
  logic [15:0]     collision_cnt;
  logic [3:0]      collision_cnt_s;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int               m_ptr;
  int               m_cnt;
  int               m_cnt_s;
  logic [NP-1:0]    exp_ready;
  logic [NP*DP-1:0] exp_next_port;
  logic [NP*DP-1:0] exp_port;
  logic [DP-1:0]    exp_out;
  bit               m_collided;

  always #5 clk = ~clk;

  write_port_decoder #(.ADDR_WIDTH(AW), .NUM_PORTS(NP), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .enable_port(enable_port), .enable_out(enable_out),
    .collision_cnt(collision_cnt));

  write_port_decoder #(.ADDR_WIDTH(AW), .NUM_PORTS(NP), .CNT_WIDTH(4)) dut_s (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready_s), .enable_port(enable_port_s), .enable_out(enable_out_s),
    .collision_cnt(collision_cnt_s));

  // Apply inputs and compute the expected acceptance by walking ports in priority order.
  task automatic drive(input logic rst, input logic [NP-1:0] v, input int a0, input int a1);
    bit [DP-1:0] claimed;
    int p, a;
    reset     = rst;
    req_valid = v;
    req_addr  = {AW'(a1), AW'(a0)};
    exp_ready = '0;
    exp_next_port = '0;
    m_collided = 1'b0;
    claimed = '0;
    if (!rst) begin
      for (int k = 0; k < NP; k++) begin
        p = (m_ptr + k) % NP;
        a = (p == 0) ? a0 : a1;
        if (v[p]) begin
`ifdef WRITE_PORT_DECODER_ZERO_MASK_EN
          if (a == 0) exp_ready[p] = 1'b1;
          else
`endif
          if (claimed[a]) m_collided = 1'b1;
          else begin
            claimed[a] = 1'b1;
            exp_ready[p] = 1'b1;
            exp_next_port[p*DP + a] = 1'b1;
          end
        end
      end
    end
    #1;
  endtask

  // Advance one clock and update the model's registered view.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      exp_port = '0; m_cnt = 0; m_cnt_s = 0; m_ptr = 0;
    end else begin
      exp_port = exp_next_port;
      if (m_collided) begin
        m_ptr = (m_ptr + 1) % NP;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 15) m_cnt_s++;
      end
    end
    exp_out = exp_port[DP-1:0] | exp_port[2*DP-1:DP];
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    drive(1'b1, 2'b11, 14, 3);
    n_checks++;
    if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
    tick();
    n_checks++;
    if (enable_out !== 32'h0 || enable_port !== '0) begin n_fail++; $display("FAIL reset_enable: got %h expected 0", enable_out); end
    n_checks++;
    if (collision_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %h expected 0", collision_cnt); end
  endtask

  task automatic test_idle();
    @(negedge clk);
    drive(1'b0, 2'b00, 0, 0);
    n_checks++;
    if (req_ready !== 2'b00) begin n_fail++; $display("FAIL idle_ready: got %b expected 00", req_ready); end
    tick();
    n_checks++;
    if (enable_out !== 32'h0 || enable_port !== '0) begin n_fail++; $display("FAIL idle_enable: got %h expected 0", enable_out); end
  endtask

  task automatic test_single();
    @(negedge clk);
    drive(1'b0, 2'b01, 14, 0);
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b expected 01", req_ready); end
    tick();
    n_checks++;
    if (enable_out !== 32'h0000_4000) begin n_fail++; $display("FAIL single_out: got %h expected 00004000", enable_out); end
    n_checks++;
    if (enable_port !== {32'h0, 32'h0000_4000}) begin n_fail++; $display("FAIL single_port: got %h expected %h", enable_port, {32'h0, 32'h0000_4000}); end
    @(negedge clk);
    drive(1'b0, 2'b00, 14, 0);
    tick();
    n_checks++;
    if (enable_out !== 32'h0) begin n_fail++; $display("FAIL single_pulse: got %h expected 0", enable_out); end
  endtask

  task automatic test_two_ports();
    int c0;
    c0 = m_cnt;
    @(negedge clk);
    drive(1'b0, 2'b11, 14, 3);
    n_checks++;
    if (req_ready !== 2'b11) begin n_fail++; $display("FAIL two_ready: got %b expected 11", req_ready); end
    tick();
    n_checks++;
    if (enable_out !== 32'h0000_4008) begin n_fail++; $display("FAIL two_out: got %h expected 00004008", enable_out); end
    n_checks++;
    if (collision_cnt !== 16'(c0)) begin n_fail++; $display("FAIL two_cnt: got %0d expected %0d", collision_cnt, c0); end
  endtask

  task automatic test_collision();
    logic [1:0] want [3];
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b0, 2'b11, 7, 7);
      n_checks++;
      if (req_ready !== want[i] || req_ready !== exp_ready) begin
        n_fail++; $display("FAIL coll_ready%0d: got %b expected %b", i, req_ready, want[i]);
      end
      tick();
      n_checks++;
      if (enable_port !== exp_port || enable_out !== 32'h80) begin
        n_fail++; $display("FAIL coll_port%0d: got %h expected %h", i, enable_port, exp_port);
      end
      n_checks++;
      if (collision_cnt !== 16'(i + 1)) begin n_fail++; $display("FAIL coll_cnt%0d: got %0d expected %0d", i, collision_cnt, i + 1); end
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    drive(1'b1, 2'b00, 0, 0);
    tick();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(1'b0, 2'b11, 9, 9);
      tick();
    end
    n_checks++;
    if (collision_cnt_s !== 4'hF || m_cnt_s != 15) begin n_fail++; $display("FAIL sat_small: got %h expected f", collision_cnt_s); end
    n_checks++;
    if (collision_cnt !== 16'd20) begin n_fail++; $display("FAIL sat_big: got %0d expected 20", collision_cnt); end
  endtask

  task automatic test_zero_addr();
    int c0;
    c0 = m_cnt;
    @(negedge clk);
    drive(1'b0, 2'b01, 0, 0);
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL zero_ready: got %b expected 01", req_ready); end
    tick();
    n_checks++;
`ifdef WRITE_PORT_DECODER_ZERO_MASK_EN
    if (enable_out !== 32'h0) begin n_fail++; $display("FAIL zero_out: got %h expected 0", enable_out); end
`else
    if (enable_out !== 32'h1) begin n_fail++; $display("FAIL zero_out: got %h expected 1", enable_out); end
`endif
    @(negedge clk);
    drive(1'b0, 2'b11, 0, 0);
    n_checks++;
    if (req_ready !== exp_ready) begin n_fail++; $display("FAIL zero_both_ready: got %b expected %b", req_ready, exp_ready); end
    tick();
    n_checks++;
    if (collision_cnt !== 16'(m_cnt) || enable_port !== exp_port) begin
      n_fail++; $display("FAIL zero_both: got cnt %0d port %h expected cnt %0d port %h", collision_cnt, enable_port, m_cnt, exp_port);
    end
`ifdef WRITE_PORT_DECODER_ZERO_MASK_EN
    n_checks++;
    if (collision_cnt !== 16'(c0)) begin n_fail++; $display("FAIL zero_nocount: got %0d expected %0d", collision_cnt, c0); end
`endif
  endtask

  task automatic test_random();
    logic rst;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 24) == 0);
      drive(rst, 2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3));
      n_checks++;
      if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, req_ready, exp_ready); end
      tick();
      n_checks++;
      if (enable_port !== exp_port || enable_out !== exp_out) begin
        n_fail++; $display("FAIL rand_enable[%0d]: got %h/%h expected %h/%h", i, enable_port, enable_out, exp_port, exp_out);
      end
      n_checks++;
      if (collision_cnt !== 16'(m_cnt) || collision_cnt_s !== 4'(m_cnt_s)) begin
        n_fail++; $display("FAIL rand_cnt[%0d]: got %0d/%0d expected %0d/%0d", i, collision_cnt, collision_cnt_s, m_cnt, m_cnt_s);
      end
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_addr = '0;
    m_ptr = 0; m_cnt = 0; m_cnt_s = 0;
    exp_port = '0; exp_out = '0; exp_ready = '0; exp_next_port = '0; m_collided = 1'b0;
    test_reset();
    test_idle();
    test_single();
    test_two_ports();
    test_collision();
    test_saturation();
    test_zero_addr();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
